// File: rtl/program_loader.sv
// Boot-time program loader: streams a program image into instruction memory,
// reads it back, and enables the cpu only if the additive checksum matches.
module program_loader #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 512,
    parameter int          CNT_W     = 10,
    parameter int          ADDR_STEP = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERIFY, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   sum_wr_q, sum_wr_d;
    logic [DATA_W-1:0]   sum_rd_q, sum_rd_d;
    logic                rvld_q, rvld_d;
    logic [31:0]         addr_q, addr_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_en_q, cpu_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        logic [31:0] w;
        w = 32'(idx);
        return BASE_ADDR + w * 32'(ADDR_STEP);
    endfunction

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        sum_wr_d = sum_wr_q;
        sum_rd_d = sum_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        // Read data arrives one cycle after ren_ext, so rvld trails ren by a cycle.
        rvld_d   = ren_q;
        if (rvld_q) begin
            sum_rd_d = sum_rd_q + rdata_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d = word_count;
                    if (word_count == '0 || word_count > CNT_W'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d  = S_LOAD;
                        idx_d    = '0;
                        sum_wr_d = '0;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    wen_d    = 1'b1;
                    addr_d   = word_addr(idx_q);
                    wdata_d  = s_data;
                    sum_wr_d = sum_wr_q + s_data;
                    idx_d    = idx_q + CNT_W'(1);
                    if (idx_q == n_q - CNT_W'(1)) begin
                        state_d  = S_VERIFY;
                        idx_d    = '0;
                        sum_rd_d = '0;
                    end
                end
            end
            S_VERIFY: begin
                ren_d  = 1'b1;
                addr_d = word_addr(idx_q);
                idx_d  = idx_q + CNT_W'(1);
                if (idx_q == n_q - CNT_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Compare once the last read word is being absorbed this cycle.
                if (!ren_q && rvld_q) begin
                    state_d = (sum_rd_d == sum_wr_q) ? S_RUN : S_ERROR;
                end
            end
            S_RUN, S_ERROR: begin
                if (halt) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
        done_d   = (state_d == S_RUN);
        cpu_en_d = (state_d == S_RUN);
        error_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            sum_wr_q <= '0;
            sum_rd_q <= '0;
            rvld_q   <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            wdata_q  <= '0;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            sum_wr_q <= sum_wr_d;
            sum_rd_q <= sum_rd_d;
            rvld_q   <= rvld_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            wdata_q  <= wdata_d;
            cpu_en_q <= cpu_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign s_ready    = (state_q == S_LOAD);
    assign addr_ext   = addr_q;
    assign wen_ext    = wen_q;
    assign ren_ext    = ren_q;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: expected bus events are queued by the stimulus
// and consumed by a monitor that watches the memory port and status outputs.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, halt, s_valid;
    logic [9:0]  word_count;
    logic [31:0] s_data;
    logic        s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
    logic [31:0] addr_ext, wdata_ext;
    logic [31:0] rdata_ext = '0;

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .word_count(word_count), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .addr_ext(addr_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 done rise, 3 error rise
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          corrupt_idx = -1;
    logic        done_prev = 1'b0;
    logic        error_prev = 1'b0;
    logic [31:0] mem [512];
    logic [31:0] prog [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model with one-cycle read latency and optional bit-0 corruption.
    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^
                                  ((int'(addr_ext[10:2]) == corrupt_idx) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h expected none", kind, addr, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (wen_ext && ren_ext) chk("wen_ren_exclusive", 32'(ren_ext), 32'h0);
        if (cpu_enable !== done) chk("cpu_enable_vs_done", 32'(cpu_enable), 32'(done));
        if (wen_ext) check_ev(0, addr_ext, wdata_ext);
        if (ren_ext) check_ev(1, addr_ext, 32'h0);
        if (done && !done_prev) check_ev(2, 32'h0, 32'(cyc - start_cyc));
        if (error && !error_prev) check_ev(3, 32'h0, 32'(cyc - start_cyc));
        done_prev  = done;
        error_prev = error;
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'h0);
        chk({tag, "_addr"}, addr_ext, 32'h0);
        chk({tag, "_wen"}, 32'(wen_ext), 32'h0);
        chk({tag, "_ren"}, 32'(ren_ext), 32'h0);
        chk({tag, "_wdata"}, wdata_ext, 32'h0);
        chk({tag, "_cpu_en"}, 32'(cpu_enable), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_error"}, 32'(error), 32'h0);
    endtask

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic do_start(input logic [9:0] n);
        start = 1'b1;
        word_count = n;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
    endtask

    task automatic run_load(input int gap_len, input bit expect_err);
        ev_t e;
        for (int i = 0; i < 4; i++) begin
            e.kind = 0; e.addr = 32'(i * 4); e.data = prog[i]; q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e.kind = 1; e.addr = 32'(i * 4); e.data = 32'h0; q.push_back(e);
        end
        e.kind = expect_err ? 3 : 2; e.addr = 32'h0; e.data = 32'(11 + gap_len);
        q.push_back(e);
        do_start(10'd4);
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && gap_len > 0) begin
                s_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    chk("gap_wen", 32'(wen_ext), 32'h0);
                    chk("gap_addr", addr_ext, 32'h4);
                    chk("gap_wdata", wdata_ext, prog[1]);
                end
            end
            chk("s_ready_load", 32'(s_ready), 32'h1);
            s_valid = 1'b1;
            s_data = prog[i];
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("s_ready_after_load", 32'(s_ready), 32'h0);
        for (int k = 0; k < 60; k++) begin
            if (done || error) break;
            @(posedge clk); #1;
        end
        if (!(done || error)) chk("load_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ev_t e;
        prog[0] = 32'h20080005; prog[1] = 32'h20090003;
        prog[2] = 32'h01095020; prog[3] = 32'h00000000;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; halt = 1'b0; s_valid = 1'b0;
        word_count = '0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean load, then halt
        run_load(0, 1'b0);
        chk("run_done", 32'(done), 32'h1);
        chk("run_cpu_en", 32'(cpu_enable), 32'h1);
        do_halt();
        chk_idle("halt1");

        // Load with a 3-cycle stall between the 2nd and 3rd words
        run_load(3, 1'b0);
        chk("stall_done", 32'(done), 32'h1);
        do_halt();

        // Corrupted readback of word 1
        corrupt_idx = 1;
        run_load(0, 1'b1);
        repeat (2) begin
            chk("err_error", 32'(error), 32'h1);
            chk("err_cpu_en", 32'(cpu_enable), 32'h0);
            @(posedge clk); #1;
        end
        corrupt_idx = -1;
        do_halt();
        chk_idle("halt_err");

        // Illegal word counts go straight to ERROR
        e.kind = 3; e.addr = 32'h0; e.data = 32'd1; q.push_back(e);
        do_start(10'd0);
        chk("cnt0_error", 32'(error), 32'h1);
        chk("cnt0_busy", 32'(busy), 32'h0);
        do_halt();
        chk_idle("cnt0_halt");
        q.push_back(e);
        do_start(10'd513);
        chk("cnt513_error", 32'(error), 32'h1);
        do_halt();
        chk_idle("cnt513_halt");

        // Reset after two accepted words
        for (int i = 0; i < 2; i++) begin
            e.kind = 0; e.addr = 32'(i * 4); e.data = prog[i]; q.push_back(e);
        end
        do_start(10'd4);
        s_valid = 1'b1; s_data = prog[0];
        @(posedge clk); #1;
        s_data = prog[1];
        @(posedge clk); #1;
        rst = 1'b1; s_data = prog[2];
        @(posedge clk); #1;
        chk_idle("mid_reset");
        rst = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        run_load(0, 1'b0);
        chk("after_reset_done", 32'(done), 32'h1);

        // start in RUN is ignored; halt drops cpu_enable next cycle
        do_start(10'd4);
        @(posedge clk); #1;
        chk("run_start_ignored_done", 32'(done), 32'h1);
        chk("run_start_ignored_busy", 32'(busy), 32'h0);
        do_halt();
        chk("halt_cpu_en", 32'(cpu_enable), 32'h0);
        run_load(0, 1'b0);
        chk("reload_done", 32'(done), 32'h1);
        do_halt();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time upstream feeder for the cpu top. Accepts a program as a valid/ready word stream and writes it into instruction memory through the cpu external port (addr_ext/wen_ext/wdata_ext).
- Reads the whole image back through ren_ext/rdata_ext and checks it with a 32-bit additive checksum.
- Raises the cpu enable only when the checksum matches.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 512, maximum words in instruction memory (matches the 9-bit instruction sram).
- CNT_W, 10, width of word_count; must hold DEPTH.
- ADDR_STEP, 4, byte increment of addr_ext per word.
- BASE_ADDR, 32'h0, byte address of the first word.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE.
- halt  in  1  returns the block from RUN or ERROR to IDLE.
- word_count  in  CNT_W  number of words to load; sampled on accepted start.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid and s_ready are both 1.
- s_data  in  DATA_W  stream word.
- addr_ext  out  32  instruction memory external byte address.
- wen_ext  out  1  external write enable.
- ren_ext  out  1  external read enable.
- wdata_ext  out  DATA_W  external write word.
- rdata_ext  in  DATA_W  external read word; valid the cycle after ren_ext.
- cpu_enable  out  1  drives the cpu enable input.
- busy  out  1  high in LOAD, VERIFY and CHECK.
- done  out  1  high in RUN.
- error  out  1  high in ERROR.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; index, read count, sum_wr and sum_rd clear to 0.
  - All outputs are 0: s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, cpu_enable, busy, done, error.
  - Reset has priority over every other input, in every state, including mid-load.
- Output timing: all outputs are registered. s_ready is the single exception; it is combinational and equals (state==LOAD).
- States: IDLE, LOAD, VERIFY, CHECK, RUN, ERROR.
- IDLE:
  - On start, latch word_count into N.
  - If N==0 or N>DEPTH, go to ERROR.
  - Otherwise go to LOAD with idx=0 and sum_wr=0.
- LOAD:
  - On each handshake, the next cycle has wen_ext=1, addr_ext=BASE_ADDR+idx*ADDR_STEP, wdata_ext=s_data.
  - On the same handshake, sum_wr += s_data (mod 2^32) and idx increments.
  - With no handshake, wen_ext=0 and addr_ext/wdata_ext hold.
  - Stalls of any length on s_valid low are legal.
  - The handshake that accepts word N-1 moves the block to VERIFY with idx=0 and sum_rd=0. s_ready is 0 from the next cycle.
- VERIFY:
  - Issues one read per cycle: ren_ext=1, addr_ext=BASE_ADDR+idx*ADDR_STEP, for idx 0..N-1 on N consecutive cycles. wen_ext=0.
  - Each cycle after a read, sum_rd += rdata_ext.
  - After the last read, go to CHECK; ren_ext=0.
- CHECK (1 cycle):
  - Absorbs the final rdata_ext into sum_rd.
  - The next state compares sum_wr to sum_rd: equal goes to RUN, unequal goes to ERROR.
- RUN: cpu_enable=1 and done=1, both held. halt moves to IDLE; cpu_enable drops the next cycle.
- ERROR: error=1 and cpu_enable=0, held. halt moves to IDLE.
- start outside IDLE is ignored. halt in IDLE, LOAD, VERIFY or CHECK is ignored (only rst aborts a load).
- Simultaneous start and halt in IDLE: start wins.
- wen_ext and ren_ext are never both 1.
- Latency: a clean load of N words with no stalls reaches RUN 2N+3 cycles after the start edge.
  - start to LOAD: 1 cycle.
  - LOAD: N cycles.
  - VERIFY: N cycles.
  - CHECK: 1 cycle.
  - Compare: 1 cycle.
- Address wrap: addr_ext is 32-bit arithmetic; with N≤DEPTH it never wraps when BASE_ADDR=0.

Test Plan:
- Load 4 words 0x20080005, 0x20090003, 0x01095020, 0x00000000 with s_valid held high:
  - wen_ext pulses at addr 0x0, 0x4, 0x8, 0xC.
  - ren_ext pulses at the same addresses.
  - done=1 and cpu_enable=1 exactly 11 cycles after start.
- Same 4 words with s_valid low for 3 cycles between words 2 and 3:
  - No write during the gap; addr_ext/wdata_ext hold.
  - Reaches RUN 14 cycles after start.
- Memory model corrupts the readback of word 1 (flip bit 0):
  - CHECK leads to ERROR; error=1 and cpu_enable stays 0.
  - halt returns to IDLE with all outputs 0.
- start with word_count=0, then start with word_count=513:
  - Each goes to ERROR the cycle after start; no wen_ext or ren_ext ever asserted.
- rst=1 asserted after 2 of 4 words accepted:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A fresh 4-word load then completes to RUN normally.
- In RUN, pulse start (ignored, no new writes), then pulse halt:
  - cpu_enable falls the next cycle.
  - A new start loads again from addr 0x0.
